// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its operand sequencer.
package gcd_pkg;

    localparam int GCD_WIDTH               = 16;
    localparam int GCD_DEPTH_DEFAULT       = 4;
    localparam int GCD_LOAD_CYCLES_DEFAULT = 2;
    localparam int GCD_TIMEOUT_DEFAULT     = 70000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gcd_seq_state_t;

    // Bits needed to hold the values 0 .. max_val-1 (at least one bit).
    function automatic int gcd_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of {x,y} operand pairs with count-based full/empty flags.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = GCD_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_x,
    input  logic [WIDTH-1:0] push_y,
    input  logic             pop,
    output logic [WIDTH-1:0] head_x,
    output logic [WIDTH-1:0] head_y,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = gcd_cnt_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO refuses a push even when the same cycle also pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_x, head_y} = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {push_x, push_y};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Streams operand pairs into the GCD core and presents {x, y, gcd, err} as results.
//   state | meaning
//   IDLE  | waiting for a pair in the FIFO; pops head into core_xi/core_yi
//   LOAD  | core_rst low for LOAD_CYCLES cycles so the core loads operands
//   RUN   | core_rst high; waiting for a 0->1 edge on core_rdy or timeout
//   DONE  | result held on the out port until out_ready
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH       = GCD_WIDTH,
    parameter int DEPTH       = GCD_DEPTH_DEFAULT,
    parameter int LOAD_CYCLES = GCD_LOAD_CYCLES_DEFAULT,
    parameter int TIMEOUT     = GCD_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] core_xi,
    output logic [WIDTH-1:0] core_yi,
    output logic             core_rst,
    input  logic [WIDTH-1:0] core_xo,
    input  logic             core_rdy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
);

    localparam int TMO_W = gcd_cnt_width(TIMEOUT);
    localparam int LD_W  = gcd_cnt_width(LOAD_CYCLES);
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT - 1);
    localparam logic [LD_W-1:0]  LD_INIT  = LD_W'(LOAD_CYCLES - 1);

    gcd_seq_state_t   state_q, state_d;
    logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] core_xi_q, core_xi_d;
    logic [WIDTH-1:0] core_yi_q, core_yi_d;
    logic [WIDTH-1:0] out_x_q, out_x_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
    logic             out_err_q, out_err_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_x;
    logic [WIDTH-1:0] head_y;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .push_x (in_x),
        .push_y (in_y),
        .pop    (fifo_pop),
        .head_x (head_x),
        .head_y (head_y),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ld_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            rdy_q     <= 1'b0;
            core_xi_q <= '0;
            core_yi_q <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_gcd_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            rdy_q     <= rdy_d;
            core_xi_q <= core_xi_d;
            core_yi_q <= core_yi_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_gcd_q <= out_gcd_d;
            out_err_q <= out_err_d;
        end
    end

    // rdy_q tracks core_rdy through LOAD as well, so a level left high by the
    // previous operation is already seen as 1 when RUN begins.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        rdy_d     = core_rdy;
        core_xi_d = core_xi_q;
        core_yi_d = core_yi_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_gcd_d = out_gcd_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    core_xi_d = head_x;
                    core_yi_d = head_y;
                    if ((head_x == '0) || (head_y == '0)) begin
                        out_x_d   = head_x;
                        out_y_d   = head_y;
                        out_gcd_d = '0;
                        out_err_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        ld_cnt_d = LD_INIT;
                        rdy_d    = 1'b0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                tmo_cnt_d = TMO_INIT;
                if (ld_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    ld_cnt_d = ld_cnt_q - LD_W'(1);
                end
            end
            RUN: begin
                if (core_rdy && !rdy_q) begin
                    out_x_d   = core_xi_q;
                    out_y_d   = core_yi_q;
                    out_gcd_d = core_xo;
                    out_err_d = 1'b0;
                    state_d   = DONE;
                end else if (tmo_cnt_q == '0) begin
                    out_x_d   = core_xi_q;
                    out_y_d   = core_yi_q;
                    out_gcd_d = '0;
                    out_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_rst  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            RUN:     core_rst  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE) || !fifo_empty;
    assign core_xi = core_xi_q;
    assign core_yi = core_yi_q;
    assign out_x   = out_x_q;
    assign out_y   = out_y_q;
    assign out_gcd = out_gcd_q;
    assign out_err = out_err_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Randomised and directed bench for gcd_operand_sequencer against a queue-based result model.
module tb_gcd_operand_sequencer;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [15:0] core_xi;
    logic [15:0] core_yi;
    logic        core_rst;
    logic [15:0] core_xo;
    logic        core_rdy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [15:0] out_gcd;
    logic        out_err;
    logic        busy;

    gcd_operand_sequencer #(
        .WIDTH       (16),
        .DEPTH       (4),
        .LOAD_CYCLES (2),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .core_xi   (core_xi),
        .core_yi   (core_yi),
        .core_rst  (core_rst),
        .core_xo   (core_xo),
        .core_rdy  (core_rdy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_gcd   (out_gcd),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] g;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc_cnt = 0;
    int   run_seen = 0;
    int   stub_mode = 0;   // 0 normal, 1 rdy stuck low, 2 rdy stuck high
    int   run_cnt = 0;

    function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
        int unsigned p = a;
        int unsigned q = b;
        int unsigned t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p[15:0];
    endfunction

    // Core stub: rdy rises once it has been running for more than lat cycles.
    function automatic int stub_lat(input logic [15:0] x, input logic [15:0] y);
        return ((int'(x) + int'(y)) % 110) + 1;
    endfunction

    // Rdy first seen in RUN cycle lat+1; the sequencer gives up after TMO RUN cycles.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int mode);
        exp_t e;
        e.x = x;
        e.y = y;
        e.g = '0;
        e.e = 1'b0;
        if (x == 0 || y == 0) return e;
        if (mode != 0 || stub_lat(x, y) + 1 > TMO) e.e = 1'b1;
        else e.g = gcd_ref(x, y);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!core_rst) run_cnt <= 0;
        else run_cnt <= run_cnt + 1;
    end

    always_comb begin
        core_xo  = gcd_ref(core_xi, core_yi);
        core_rdy = 1'b0;
        case (stub_mode)
            1:       core_rdy = 1'b0;
            2:       core_rdy = 1'b1;
            default: core_rdy = core_rst && (run_cnt >= stub_lat(core_xi, core_yi));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare process: result port against the model queue, then record accepted pushes.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got x=%0d y=%0d gcd=%0d err=%0d, expected none",
                             out_x, out_y, out_gcd, out_err);
                end else begin
                    check("out_x", 32'(out_x), 32'(exp_q[0].x));
                    check("out_y", 32'(out_y), 32'(exp_q[0].y));
                    check("out_gcd", 32'(out_gcd), 32'(exp_q[0].g));
                    check("out_err", 32'(out_err), 32'(exp_q[0].e));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (core_rst) begin
                run_seen++;
                if (exp_q.size() != 0) begin
                    check("core_xi_run", 32'(core_xi), 32'(exp_q[0].x));
                    check("core_yi_run", 32'(core_yi), 32'(exp_q[0].y));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_x, in_y, stub_mode));
                acc_cnt++;
            end
        end
    end

    task automatic push_measure(input logic [15:0] x, input logic [15:0] y, output int n);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 400) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()) + 32'(busy), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        int r0;
        int pushed;
        int guard;
        logic acc;
        logic [15:0] rx;
        logic [15:0] ry;
        int k;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_core_rst", 32'(core_rst), 0);
        check("rst_core_xi", 32'(core_xi), 0);
        check("rst_out_gcd", 32'(out_gcd), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        // (42,18): stub latency 61 -> out_valid 5+61 cycles after the push edge
        set_ready(1'b1);
        push_measure(16'd42, 16'd18, n);
        check("lat_normal", 32'(n), 66);
        check("lit_gcd_42_18", 32'(out_gcd), 6);
        check("lit_x_42", 32'(out_x), 42);
        check("lit_y_18", 32'(out_y), 18);
        check("lit_err_42_18", 32'(out_err), 0);
        drain();

        r0 = run_seen;
        push_measure(16'd0, 16'd7, n);
        check("lat_zero", 32'(n), 2);
        check("lit_gcd_0_7", 32'(out_gcd), 0);
        check("lit_y_7", 32'(out_y), 7);
        drain();
        check("zero_never_runs", 32'(run_seen - r0), 0);

        stub_mode = 1;
        push_measure(16'd12, 16'd8, n);
        check("lat_timeout", 32'(n), 104);
        check("lit_tmo_err", 32'(out_err), 1);
        check("lit_tmo_gcd", 32'(out_gcd), 0);
        drain();
        stub_mode = 0;
        push_measure(16'd9, 16'd6, n);
        check("lat_after_tmo", 32'(n), 21);
        check("lit_gcd_9_6", 32'(out_gcd), 3);
        drain();

        stub_mode = 2;
        push_measure(16'd20, 16'd8, n);
        check("lat_stale_rdy", 32'(n), 104);
        check("lit_stale_err", 32'(out_err), 1);
        drain();
        stub_mode = 0;

        // Back-pressure: 6 back-to-back pushes, room for DEPTH + 1 in flight
        set_ready(1'b0);
        a0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_x = 16'(10 * (i + 1));
            in_y = 16'(4 * (i + 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(acc_cnt - a0), 5);
        check("bp_in_ready_low", 32'(in_ready), 0);
        set_ready(1'b1);
        drain();

        // Hold a result with out_ready low; the compare process checks it every cycle
        set_ready(1'b0);
        push_measure(16'hFFFF, 16'hFFFF, n);
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_gcd", 32'(out_gcd), 32'hFFFF);
        end
        set_ready(1'b1);
        drain();

        // Asynchronous reset mid-RUN
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x = 16'hFFFF;
        in_y = 16'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard = 0;
        while (!core_rst && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_run_reached", 32'(core_rst), 1);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_core_rst", 32'(core_rst), 0);
        check("arst_core_xi", 32'(core_xi), 0);
        check("arst_core_yi", 32'(core_yi), 0);
        check("arst_out_x", 32'(out_x), 0);
        check("arst_out_y", 32'(out_y), 0);
        check("arst_out_gcd", 32'(out_gcd), 0);
        check("arst_out_err", 32'(out_err), 0);
        check("arst_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_busy", 32'(busy), 0);

        // Randomised traffic with random back-pressure
        pushed = 0;
        guard = 0;
        while (pushed < 60 && guard < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) pushed++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if (pushed < 60 && $urandom_range(0, 2) != 0) begin
                    case ($urandom_range(0, 7))
                        0: begin rx = 16'd0; ry = 16'($urandom); end
                        1: begin rx = 16'($urandom); ry = 16'd0; end
                        2, 3: begin
                            k  = int'($urandom_range(1, 60));
                            rx = 16'(k * int'($urandom_range(1, 900)));
                            ry = 16'(k * int'($urandom_range(1, 900)));
                        end
                        default: begin rx = 16'($urandom); ry = 16'($urandom); end
                    endcase
                    in_valid = 1'b1;
                    in_x = rx;
                    in_y = ry;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("rand_pushed", 32'(pushed), 60);
        set_ready(1'b1);
        drain();
        @(negedge clk);
        check("final_in_ready", 32'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
